rf_scoreboard: RTL
==================

Name: rf_scoreboard

Overview:
- Register-file hazard scoreboard for the 5-stage in-order pipeline; sits beside ID and observes the WB register-file write bus.
- Keeps a per-register count of in-flight writes: incremented when ID issues a writing instruction to EX, decremented when WB performs the write.
- Drives the ID stall for read-after-write hazards, which lets the non-forwarding pipeline interlock without comparing dest fields of every stage.

Parameters:
- NREG, 32, number of architectural registers (index 0 hardwired zero, never tracked).
- CNT_W, 2, width of each per-register pending counter; max count = 2^CNT_W-1.
- TOT_W, 4, width of the pending_total output.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- issue_fire  input  1  ID->EX handshake fired this cycle (ds_valid & ds_ready_go & es_allowin).
- issue_we  input  1  issuing instruction writes the register file.
- issue_dest  input  5  destination register of the issuing instruction.
- rs1_used  input  1  ID instruction reads rs1.
- rs1_addr  input  5  rs1 index.
- rs2_used  input  1  ID instruction reads rs2.
- rs2_addr  input  5  rs2 index.
- retire_we  input  1  WB register write this cycle (rf_we, already gated by ws_valid).
- retire_dest  input  5  WB write address.
- flush  input  1  pipeline flush; all in-flight instructions discarded.
- stall  output  1  ID must not issue (RAW hazard on a used source).
- busy_vec  output  NREG  bit r = counter[r] != 0.
- pending_total  output  TOT_W  sum of all counters.
- sb_err  output  1  sticky protocol error flag.

Behaviour:
- State: NREG-1 counters cnt[1..NREG-1] of CNT_W bits, pending_total register, sb_err register. All are reset to 0. busy_vec, stall and pending_total read 0 out of reset.
- Index 0: issue or retire with dest 0 has no effect. A source address of 0 never causes a stall.
- inc[r] = issue_fire & issue_we & issue_dest==r & r!=0. dec[r] = retire_we & retire_dest==r & r!=0.
- Per-cycle update of cnt[r]:
  - inc & dec: unchanged (simultaneous issue and retire on the same register).
  - inc only: +1. If cnt[r] already equals the max, hold cnt[r] and set sb_err.
  - dec only: -1. If cnt[r] is already 0, hold at 0 and set sb_err.
  - neither: unchanged.
- pending_total tracks the sum of the counters, updated in the same cycle by the same inc/dec rules. A saturated or ignored event does not change it.
- stall (combinational from registered counters only) = (rs1_used & rs1_addr!=0 & cnt[rs1_addr]!=0) | (rs2_used & rs2_addr!=0 & cnt[rs2_addr]!=0).
- There is no same-cycle retire bypass. The RF write lands at the clock edge, so stall stays high in the cycle WB writes the source and drops in the next cycle.
- stall does not depend on issue_fire (no combinational loop through es_allowin).
- If issue_fire is asserted while stall=1, the counters still update as specified (the upstream is responsible for this). sb_err is not set in this case.
- flush: on the next edge all counters and pending_total become 0; inc/dec events in that cycle are ignored. sb_err is not cleared by flush.
- sb_err: sticky; cleared only by reset.
- reset mid-operation: all state returns to 0 at the edge regardless of the other inputs.

Test Plan:
- Reset with all inputs active -> next cycle: busy_vec=0, stall=0, pending_total=0, sb_err=0.
- Issue we, dest=5 at cycle 0; ID reads rs1=5 (used) -> stall=1 from cycle 1. Retire dest=5 at cycle 3 -> stall still 1 in cycle 3, stall=0 in cycle 4, busy_vec[5]=0.
- Back-to-back issue dest=7 twice, then issue dest=7 together with retire dest=7 -> cnt[7]=2 throughout the simultaneous cycle, pending_total=2. Two more retires -> 0.
- Issue dest=0 and rs1=0 used -> busy_vec=0, stall=0, pending_total=0. Retire dest=0 -> no error.
- Four issues to dest=3 (CNT_W=2) -> cnt[3]=3, sb_err=1 after the 4th. Retire with all counters 0 -> cnt held at 0, sb_err remains 1.
- Issues to dest 1, 2, 3, then flush asserted together with a retire of dest 1 -> next cycle busy_vec=0, pending_total=0, stall=0 for rs1=2, and sb_err unchanged.

Source files
------------

// File: rtl/rf_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard_if
// Brief    : ID/WB-side signal bundle for the register-file hazard scoreboard.
// Revision : 1.0
// ============================================================================
interface rf_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int TOT_W = 4
);
  localparam int AW = $clog2(NREG);

  logic             issue_fire;
  logic             issue_we;
  logic [AW-1:0]    issue_dest;
  logic             rs1_used;
  logic [AW-1:0]    rs1_addr;
  logic             rs2_used;
  logic [AW-1:0]    rs2_addr;
  logic             retire_we;
  logic [AW-1:0]    retire_dest;
  logic             flush;
  logic             stall;
  logic [NREG-1:0]  busy_vec;
  logic [TOT_W-1:0] pending_total;
  logic             sb_err;

  modport master (
    output issue_fire, issue_we, issue_dest,
    output rs1_used, rs1_addr, rs2_used, rs2_addr,
    output retire_we, retire_dest, flush,
    input  stall, busy_vec, pending_total, sb_err
  );

  modport slave (
    input  issue_fire, issue_we, issue_dest,
    input  rs1_used, rs1_addr, rs2_used, rs2_addr,
    input  retire_we, retire_dest, flush,
    output stall, busy_vec, pending_total, sb_err
  );
endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Per-register in-flight write counters driving the ID RAW stall.
// Revision : 1.0
// ============================================================================
module rf_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int TOT_W = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  rf_scoreboard_if.slave    sb
);
  localparam int              AW        = $clog2(NREG);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0] r_cnt [NREG];
  logic [TOT_W-1:0] r_total;
  logic             r_err;

  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_dec;
  logic [NREG-1:0]  w_full;
  logic [NREG-1:0]  w_empty;
  logic [NREG-1:0]  w_busy;
  logic             w_eff_inc;
  logic             w_eff_dec;
  logic             w_err_ev;

  // Register 0 is hardwired zero: it never counts and never reads as busy.
  genvar g;
  for (g = 0; g < NREG; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign w_inc[g]   = 1'b0;
      assign w_dec[g]   = 1'b0;
      assign w_full[g]  = 1'b0;
      assign w_empty[g] = 1'b1;
      assign w_busy[g]  = 1'b0;
    end else begin : g_track
      assign w_inc[g]   = sb.issue_fire & sb.issue_we & (sb.issue_dest == AW'(g));
      assign w_dec[g]   = sb.retire_we & (sb.retire_dest == AW'(g));
      assign w_full[g]  = (r_cnt[g] == c_cnt_max);
      assign w_empty[g] = (r_cnt[g] == '0);
      assign w_busy[g]  = ~w_empty[g];
    end
  end

  // A same-register issue+retire cancels; saturating events change nothing.
  assign w_eff_inc = |(w_inc & ~w_dec & ~w_full);
  assign w_eff_dec = |(w_dec & ~w_inc & ~w_empty);
  assign w_err_ev  = |(w_inc & ~w_dec & w_full) | |(w_dec & ~w_inc & w_empty);

  always_ff @(posedge clk) begin
    if (reset || sb.flush) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
      r_total <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r] && !w_full[r]) begin
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        end else if (w_dec[r] && !w_inc[r] && !w_empty[r]) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
        end
      end
      r_total <= r_total + {{(TOT_W-1){1'b0}}, w_eff_inc}
                         - {{(TOT_W-1){1'b0}}, w_eff_dec};
    end
  end

  // Sticky: only reset clears it; events during a flush are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (!sb.flush && w_err_ev) begin
      r_err <= 1'b1;
    end
  end

  // Stall looks only at registered counters, never at issue_fire.
  assign sb.stall = (sb.rs1_used & (sb.rs1_addr != '0) & w_busy[sb.rs1_addr])
                  | (sb.rs2_used & (sb.rs2_addr != '0) & w_busy[sb.rs2_addr]);
  assign sb.busy_vec      = w_busy;
  assign sb.pending_total = r_total;
  assign sb.sb_err        = r_err;
endmodule
`default_nettype wire
